bisonn_mul_req: RTL and testbench
=================================

BISONN_MUL_REQ -- requirements
Module: bisonn_mul_req

Interface
REQ-001 SHALL have parameter RSP_DEPTH, default 4, response FIFO entries (power of two, >=4).
REQ-002 SHALL have clk_i  input  1  clock, rising edge.
REQ-003 SHALL have rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid_i  input  1  operand pair offered.
REQ-005 SHALL have req_ready_o  output  1  operand pair accepted this cycle when high with req_valid_i.
REQ-006 SHALL have req_rs1_i, req_rs2_i  input  64 each  unsigned operands.
REQ-007 SHALL have rsp_valid_o  output  1  product available.
REQ-008 SHALL have rsp_ready_i  input  1  consumer takes product.
REQ-009 SHALL have rsp_rd_o  output  64  low 64 bits of unsigned product.
REQ-010 SHALL have mul_free_i  input  1  no scalar MUL-unit instruction presented to the multiplier this cycle.
REQ-011 SHALL have flush_mul_i  input  1  the multiplier's flush, same cycle the multiplier sees it.
REQ-012 SHALL have bisonn_valid_o, bisonn_rs1_o, bisonn_rs2_o  output  1/64/64  request port into multiplier.
REQ-013 SHALL have bisonn_valid_i, bisonn_rd_i  input  1/64  result port from multiplier.
REQ-014 SHALL have perf_issued_o, perf_replay_o  output  32 each  counters (see Configuration).

Function
REQ-015 Multiplier contract: request issued in cycle T returns with bisonn_valid_i in T+2; no backpressure on return.
REQ-016 Issue permitted in a cycle only if mul_free_i=1, flush_mul_i=0, and fifo_count + inflight + replay_count < RSP_DEPTH.
REQ-017 Issue source priority: replay queue head first; new request only when replay queue empty.
REQ-018 req_ready_o = issue permitted and replay queue empty and no corrupt return this cycle; acceptance drives bisonn_valid_o=1 with req operands in the same cycle.
REQ-019 bisonn_rs1_o/rs2_o SHALL be 0 whenever bisonn_valid_o=0.
REQ-020 In-flight tracker: 2-slot shift register (S0 = issued this cycle, S1 = issued last cycle) holding operands and corrupt bit.
REQ-021 flush_mul_i=1 in cycle C SHALL set corrupt bit of the entry issued in C-1.
REQ-022 Return with corrupt=0: bisonn_rd_i written to response FIFO at end of return cycle; rsp_valid_o high from next cycle.
REQ-023 Return with corrupt=1: bisonn_rd_i dropped, operands pushed to 2-entry replay queue; new requests blocked that cycle.
REQ-024 Responses SHALL be delivered in request acceptance order, including across replays.
REQ-025 bisonn_valid_i with no tracked in-flight entry SHALL be ignored.
REQ-026 FIFO: simultaneous push and pop with full FIFO allowed; pop on rsp_valid_o & rsp_ready_i; overflow impossible by REQ-016.
REQ-027 rsp_rd_o SHALL be 0 while rsp_valid_o=0.

Reset
REQ-028 rstn_i low SHALL immediately clear FIFO, tracker, replay queue, counters; all outputs 0.
REQ-029 Reset mid-operation SHALL discard all in-flight and queued work; late bisonn_valid_i after reset ignored per REQ-025.

Configuration
REQ-030 Macro BISONN_REQ_PERF_EN defined: perf_issued_o counts cycles with bisonn_valid_o=1, perf_replay_o counts replay issues; both wrap at 2^32.
REQ-031 Macro BISONN_REQ_PERF_EN undefined: counters not implemented, perf_issued_o and perf_replay_o tied to 0.

Verification
REQ-032 rs1=3, rs2=5, mul_free_i=1, rsp_ready_i=1 -> bisonn_valid_o same cycle, rsp_valid_o with rsp_rd_o=15 three cycles after acceptance.
REQ-033 Operands 0xFFFFFFFFFFFFFFFF x 2 -> rsp_rd_o=0xFFFFFFFFFFFFFFFE.
REQ-034 Issue A=(7,6) at T, flush_mul_i at T+1, B offered continuously -> A dropped at T+2, reissued, responses 42 then B's product, perf_replay_o=1.
REQ-035 rsp_ready_i=0 with RSP_DEPTH=4, 8 requests offered -> exactly 4 accepted, req_ready_o low until a pop, no product lost.
REQ-036 mul_free_i=0 for 5 cycles with req_valid_i=1 -> no bisonn_valid_o, req_ready_o=0; issue in first cycle mul_free_i=1.
REQ-037 rstn_i low one cycle after issue -> all outputs 0, returning bisonn_valid_i produces no rsp_valid_o.

Source files
------------

// File: rtl/bisonn_mul_req.sv
// Queues operand pairs into a shared multiplier (2-cycle return), replays flushed requests and buffers products in order.
// Optional perf counters enabled with `define BISONN_REQ_PERF_EN.
module bisonn_mul_req #(
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [63:0] req_rs1_i,
   input  logic [63:0] req_rs2_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [63:0] rsp_rd_o,
   input  logic        mul_free_i,
   input  logic        flush_mul_i,
   output logic        bisonn_valid_o,
   output logic [63:0] bisonn_rs1_o,
   output logic [63:0] bisonn_rs2_o,
   input  logic        bisonn_valid_i,
   input  logic [63:0] bisonn_rd_i,
   output logic [31:0] perf_issued_o,
   output logic [31:0] perf_replay_o
);

   localparam int unsigned AW = $clog2(RSP_DEPTH);
   localparam int unsigned FW = AW + 1;
   localparam int unsigned CW = AW + 2;

   typedef struct packed {
      logic        v;
      logic        c;
      logic [63:0] rs1;
      logic [63:0] rs2;
   } slot_t;

   slot_t          t1_q, t1_d, t2_q, t2_d;
   logic [63:0]    fifo_mem [RSP_DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FW-1:0]  fcnt_q, fcnt_d;
   logic [63:0]    rq_rs1_q [2];
   logic [63:0]    rq_rs2_q [2];
   logic           rq_head_q;
   logic [1:0]     rq_cnt_q, rq_cnt_d;
   logic [CW-1:0]  occ;
   logic           issue_ok, rq_empty, rep_issue, new_issue;
   logic           ret_good, ret_bad, pop;

   always_comb begin
      occ         = CW'(fcnt_q) + CW'(t1_q.v) + CW'(t2_q.v) + CW'(rq_cnt_q);
      issue_ok    = rstn_i & mul_free_i & ~flush_mul_i & (occ < CW'(RSP_DEPTH));
      ret_good    = t2_q.v & bisonn_valid_i & ~t2_q.c;
      ret_bad     = t2_q.v & bisonn_valid_i & t2_q.c;
      rq_empty    = (rq_cnt_q == 2'd0);
      rep_issue   = issue_ok & ~rq_empty;
      req_ready_o = issue_ok & rq_empty & ~ret_bad;
      new_issue   = req_ready_o & req_valid_i;

      bisonn_valid_o = rep_issue | new_issue;
      bisonn_rs1_o   = '0;
      bisonn_rs2_o   = '0;
      if (rep_issue) begin
         bisonn_rs1_o = rq_rs1_q[rq_head_q];
         bisonn_rs2_o = rq_rs2_q[rq_head_q];
      end else if (new_issue) begin
         bisonn_rs1_o = req_rs1_i;
         bisonn_rs2_o = req_rs2_i;
      end

      rsp_valid_o = (fcnt_q != '0);
      rsp_rd_o    = rsp_valid_o ? fifo_mem[rd_ptr_q] : '0;
      pop         = rsp_valid_o & rsp_ready_i;
      fcnt_d      = fcnt_q + FW'(ret_good) - FW'(pop);
      rq_cnt_d    = rq_cnt_q + 2'(ret_bad) - 2'(rep_issue);

      t1_d     = '{v: bisonn_valid_o, c: 1'b0, rs1: bisonn_rs1_o, rs2: bisonn_rs2_o};
      // A flush hits whatever the multiplier took one cycle earlier
      t2_d     = t1_q;
      t2_d.c   = t1_q.c | flush_mul_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         t1_q      <= '0;
         t2_q      <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fcnt_q    <= '0;
         rq_head_q <= 1'b0;
         rq_cnt_q  <= '0;
      end else begin
         t1_q     <= t1_d;
         t2_q     <= t2_d;
         fcnt_q   <= fcnt_d;
         rq_cnt_q <= rq_cnt_d;
         if (ret_good)  wr_ptr_q  <= wr_ptr_q + AW'(1);
         if (pop)       rd_ptr_q  <= rd_ptr_q + AW'(1);
         if (rep_issue) rq_head_q <= ~rq_head_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (ret_good) fifo_mem[wr_ptr_q] <= bisonn_rd_i;
      // Tail slot is head^count[0]; also correct when the head pops in the same cycle
      if (ret_bad) begin
         rq_rs1_q[rq_head_q ^ rq_cnt_q[0]] <= t2_q.rs1;
         rq_rs2_q[rq_head_q ^ rq_cnt_q[0]] <= t2_q.rs2;
      end
   end

`ifdef BISONN_REQ_PERF_EN
   logic [31:0] perf_iss_q, perf_rep_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         perf_iss_q <= '0;
         perf_rep_q <= '0;
      end else begin
         if (bisonn_valid_o) perf_iss_q <= perf_iss_q + 32'd1;
         if (rep_issue)      perf_rep_q <= perf_rep_q + 32'd1;
      end
   end

   assign perf_issued_o = perf_iss_q;
   assign perf_replay_o = perf_rep_q;
`else
   assign perf_issued_o = '0;
   assign perf_replay_o = '0;
`endif

endmodule

// File: tb/tb_bisonn_mul_req.sv
// Directed bench for bisonn_mul_req with a 2-cycle multiplier model that corrupts flushed results.
module tb_bisonn_mul_req;

   logic        clk = 1'b0;
   logic        rstn_i, req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
   logic [63:0] req_rs1_i, req_rs2_i, rsp_rd_o;
   logic        mul_free_i, flush_mul_i, bisonn_valid_o, bisonn_valid_i;
   logic [63:0] bisonn_rs1_o, bisonn_rs2_o, bisonn_rd_i;
   logic [31:0] perf_issued_o, perf_replay_o;

   always #5 clk = ~clk;

   bisonn_mul_req #(.RSP_DEPTH(4)) dut (
      .clk_i(clk), .rstn_i(rstn_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rd_o(rsp_rd_o),
      .mul_free_i(mul_free_i), .flush_mul_i(flush_mul_i),
      .bisonn_valid_o(bisonn_valid_o), .bisonn_rs1_o(bisonn_rs1_o), .bisonn_rs2_o(bisonn_rs2_o),
      .bisonn_valid_i(bisonn_valid_i), .bisonn_rd_i(bisonn_rd_i),
      .perf_issued_o(perf_issued_o), .perf_replay_o(perf_replay_o)
   );

   // External multiplier: returns two cycles after issue, garbles the result if flushed
   logic        m1_v = 1'b0, m2_v = 1'b0;
   logic [63:0] m1_p = '0, m2_p = '0;
   always @(posedge clk) begin
      m2_v <= m1_v;
      m2_p <= flush_mul_i ? ~m1_p : m1_p;
      m1_v <= bisonn_valid_o;
      m1_p <= bisonn_rs1_o * bisonn_rs2_o;
   end
   assign bisonn_valid_i = m2_v;
   assign bisonn_rd_i    = m2_p;

   int unsigned n_chk = 0, n_fail = 0;
   logic [63:0] exp_q [$];
   logic [63:0] prod;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: expected product captured on acceptance, compared on every pop
   always @(negedge clk) begin
      if (req_valid_i && req_ready_o) begin
         prod = req_rs1_i * req_rs2_i;
         exp_q.push_back(prod);
      end
      if (rsp_valid_o && rsp_ready_i) begin
         if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
         else chk("rsp_order", rsp_rd_o, exp_q.pop_front());
      end
      if (!bisonn_valid_o) chk("bisonn_ops_zero", bisonn_rs1_o | bisonn_rs2_o, 64'd0);
      if (!rsp_valid_o) chk("rsp_rd_zero", rsp_rd_o, 64'd0);
   end

   task automatic drain();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] p;
   } vec_t;
   vec_t vecs [7];

   int unsigned acc;
   logic [31:0] exp_rep, exp_iss;

   initial begin
      vecs[0] = '{64'd3, 64'd5, 64'd15};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[2] = '{64'd0, 64'd123, 64'd0};
      vecs[3] = '{64'd1, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
      vecs[4] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd0};
      vecs[5] = '{64'h1_0000_0001, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[6] = '{64'h1_2345_6789, 64'h10, 64'h12_3456_7890};

      rstn_i = 1'b0; req_valid_i = 1'b1; req_rs1_i = 64'd3; req_rs2_i = 64'd5;
      mul_free_i = 1'b1; flush_mul_i = 1'b0; rsp_ready_i = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready_o), 64'd0);
      chk("rst_bisonn_valid", 64'(bisonn_valid_o), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("rst_perf", 64'({perf_issued_o, perf_replay_o}), 64'd0);
      tick();
      rstn_i = 1'b1; req_valid_i = 1'b0;
      tick();

      // Single transactions: same-cycle issue, product three cycles after acceptance
      for (int i = 0; i < 7; i++) begin
         req_valid_i = 1'b1; req_rs1_i = vecs[i].a; req_rs2_i = vecs[i].b;
         @(negedge clk);
         chk("vec_ready", 64'(req_ready_o), 64'd1);
         chk("vec_issue", 64'(bisonn_valid_o), 64'd1);
         chk("vec_rs1", bisonn_rs1_o, vecs[i].a);
         chk("vec_rs2", bisonn_rs2_o, vecs[i].b);
         tick();
         req_valid_i = 1'b0;
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("vec_early", 64'(rsp_valid_o), 64'd0);
            tick();
         end
         @(negedge clk);
         chk("vec_valid", 64'(rsp_valid_o), 64'd1);
         chk("vec_prod", rsp_rd_o, vecs[i].p);
         tick();
         @(negedge clk);
         chk("vec_after", 64'(rsp_valid_o), 64'd0);
         tick();
      end

      // Flush one cycle after issuing A: A replays ahead of B
      req_valid_i = 1'b1; req_rs1_i = 64'd7; req_rs2_i = 64'd6;
      @(negedge clk);
      chk("flush_accept_a", 64'(req_ready_o), 64'd1);
      tick();
      req_rs1_i = 64'd9; req_rs2_i = 64'd4; flush_mul_i = 1'b1;
      @(negedge clk);
      chk("flush_block", 64'(req_ready_o | bisonn_valid_o), 64'd0);
      tick();
      flush_mul_i = 1'b0;
      @(negedge clk);
      chk("corrupt_ret_block", 64'(req_ready_o | bisonn_valid_o), 64'd0);
      tick();
      @(negedge clk);
      chk("replay_issue", 64'(bisonn_valid_o), 64'd1);
      chk("replay_rs1", bisonn_rs1_o, 64'd7);
      chk("replay_ready", 64'(req_ready_o), 64'd0);
      tick();
      @(negedge clk);
      chk("accept_b", 64'(req_ready_o), 64'd1);
      tick();
      req_valid_i = 1'b0;
      drain();
`ifdef BISONN_REQ_PERF_EN
      exp_rep = 32'd1; exp_iss = 32'd10;
`else
      exp_rep = 32'd0; exp_iss = 32'd0;
`endif
      chk("perf_replay", 64'(perf_replay_o), 64'(exp_rep));
      chk("perf_issued", 64'(perf_issued_o), 64'(exp_iss));

      // Backpressure: only RSP_DEPTH accepted while consumer stalls
      rsp_ready_i = 1'b0; acc = 0;
      for (int c = 0; c < 20; c++) begin
         req_valid_i = (acc < 8); req_rs1_i = 64'(acc + 10); req_rs2_i = 64'(acc + 3);
         @(negedge clk);
         if (req_valid_i && req_ready_o) acc++;
         tick();
      end
      chk("bp_accepted", 64'(acc), 64'd4);
      @(negedge clk);
      chk("bp_ready_low", 64'(req_ready_o), 64'd0);
      tick();
      rsp_ready_i = 1'b1;
      for (int c = 0; c < 60 && !(acc == 8 && exp_q.size() == 0); c++) begin
         req_valid_i = (acc < 8); req_rs1_i = 64'(acc + 10); req_rs2_i = 64'(acc + 3);
         @(negedge clk);
         if (req_valid_i && req_ready_o) acc++;
         tick();
      end
      req_valid_i = 1'b0;
      chk("bp_all_accepted", 64'(acc), 64'd8);
      chk("bp_drained", 64'(exp_q.size()), 64'd0);

      // Multiplier busy for five cycles
      req_valid_i = 1'b1; req_rs1_i = 64'd11; req_rs2_i = 64'd13; mul_free_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("busy_block", 64'(req_ready_o | bisonn_valid_o), 64'd0);
         tick();
      end
      mul_free_i = 1'b1;
      @(negedge clk);
      chk("busy_release", 64'(req_ready_o & bisonn_valid_o), 64'd1);
      tick();
      req_valid_i = 1'b0;
      drain();

      // Reset one cycle after issue; the late return must be ignored
      req_valid_i = 1'b1; req_rs1_i = 64'd5; req_rs2_i = 64'd5;
      @(negedge clk);
      chk("rst_mid_issue", 64'(bisonn_valid_o), 64'd1);
      tick();
      req_valid_i = 1'b0; rstn_i = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("rst_mid_outs", 64'({req_ready_o, bisonn_valid_o, rsp_valid_o}), 64'd0);
      chk("rst_mid_ops", bisonn_rs1_o | bisonn_rs2_o | rsp_rd_o, 64'd0);
      chk("rst_mid_perf", 64'({perf_issued_o, perf_replay_o}), 64'd0);
      tick();
      rstn_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rst_late_ret", 64'(rsp_valid_o), 64'd0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
